addsub_sequencer: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract controller. Time-shares one SLICE-bit ripple add/sub

---
 rtl/addsub_sequencer_pkg.sv | 13 +
 rtl/addsub_sequencer_slice.sv | 32 +++
 rtl/addsub_sequencer.sv | 133 +++++++++++++
 tb/tb_addsub_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_sequencer_pkg.sv
// Shared types for the multi-cycle add/subtract sequencer.
package addsub_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_sequencer_slice.sv
// Combinational W-bit ripple add/sub slice: s = a + (b ^ m) + cin.
module slice_addsub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] bx;
  logic [W:0]   c;

  always_comb begin
    bx   = b ^ {W{m}};
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end
  end

  assign cout  = c[W];
  // Carry into the top bit, needed by the sequencer for signed overflow.
  assign c_msb = c[W-1];

endmodule

// File: rtl/addsub_sequencer.sv
// WIDTH-bit add/subtract that reuses one SLICE-bit slice over WIDTH/SLICE cycles, LSB first.
//   state | meaning
//   IDLE  | waiting for start; result/flags hold the last finished op
//   RUN   | processing slice idx, one slice per cycle
//   DONE  | one-cycle done pulse; start here is accepted back-to-back
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_width
    $error("addsub_sequencer: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout, sl_cmsb;

  assign sl_a = a_q[idx_q*SLICE +: SLICE];
  assign sl_b = b_q[idx_q*SLICE +: SLICE];

  slice_addsub #(.W(SLICE)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .m     (mode_q),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          mode_d   = mode;
          carry_d  = mode;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        result_d[idx_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_cout;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ADD;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with a cycle-level reference model and literal checks.
module tb_addsub_sequencer;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst, start, mode;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] result;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  addsub_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // {overflow, cout, result} from plain modular arithmetic and sign rules
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic m);
    logic [16:0] full;
    logic        v;
    full = m ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
    if (m) v = (x[15] != y[15]) && (full[15] != x[15]);
    else   v = (x[15] == y[15]) && (full[15] != x[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: age 0 = idle, 1..NSLICE = busy cycle k, NSLICE+1 = done cycle
  int          age     = 0;
  logic [17:0] m_final = '0;
  logic [17:0] m_held  = '0;

  always @(posedge clk) begin
    if (rst) begin
      age    = 0;
      m_held = '0;
    end else if (age >= 1 && age <= NSLICE) begin
      age++;
      if (age == NSLICE + 1) m_held = m_final;
    end else if (start) begin
      age     = 1;
      m_final = ref_op(a, b, mode);
      m_held  = '0;
    end else begin
      age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        eb;
      logic [17:0] shown;
      logic [15:0] mask;
      eb = (age >= 1 && age <= NSLICE);
      if (eb) begin
        mask  = 16'((32'd1 << ((age - 1) * SLICE)) - 1);
        shown = {2'b00, m_final[15:0] & mask};
      end else begin
        shown = m_held;
      end
      check("busy",     32'(busy),     32'(eb));
      check("done",     32'(done),     32'(age == NSLICE + 1));
      check("result",   32'(result),   32'(shown[15:0]));
      check("cout",     32'(cout),     32'(shown[16]));
      check("overflow", 32'(overflow), 32'(shown[17]));
    end
  end

  task automatic launch(input logic [15:0] ta, input logic [15:0] tb, input logic tm);
    start = 1'b1;
    a     = ta;
    b     = tb;
    mode  = tm;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    mode  = 1'($urandom);
  endtask

  // Called in cycle 1 of an op; returns the cycle in which done is seen.
  task automatic wait_done(input bit noise, output int n);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      start = noise && (n >= 2) && (n <= 4);
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string nm, input int n, input logic [15:0] er,
                           input logic ec, input logic eo);
    check({nm, "_latency"},  32'(n),        32'(NSLICE + 1));
    check({nm, "_result"},   32'(result),   32'(er));
    check({nm, "_cout"},     32'(cout),     32'(ec));
    check({nm, "_overflow"}, 32'(overflow), 32'(eo));
  endtask

  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tm, input logic [15:0] er, input logic ec,
                        input logic eo, input bit noise);
    int n;
    launch(ta, tb, tm);
    wait_done(noise, n);
    check_res(nm, n, er, ec, eo);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;

    check("model_add",  32'(ref_op(16'h1234, 16'h0FFF, 1'b0)), 32'({2'b00, 16'h2233}));
    check("model_sub",  32'(ref_op(16'h8000, 16'h0001, 1'b1)), 32'({2'b11, 16'h7FFF}));
    check("model_bor",  32'(ref_op(16'h0005, 16'h0007, 1'b1)), 32'({2'b00, 16'hFFFE}));
    check("model_b0",   32'(ref_op(16'hA5A5, 16'h0000, 1'b1)), 32'({2'b01, 16'hA5A5}));

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op("sub_b0",    16'hC3C3, 16'h0000, 1'b1, 16'hC3C3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op("start_noise", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_result", 32'(result), 32'h2233);

    // back-to-back: new start presented in the DONE cycle
    launch(16'h4000, 16'h4000, 1'b0);
    wait_done(1'b0, n);
    check_res("b2b_first", n, 16'h8000, 1'b0, 1'b1);
    launch(16'h0010, 16'h0010, 1'b1);
    wait_done(1'b0, n);
    check_res("b2b_second", n, 16'h0000, 1'b1, 1'b0);
    @(posedge clk); #1;

    // reset in cycle 3 of an op
    launch(16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_done",     32'(done),     32'd0);
    check("abort_result",   32'(result),   32'd0);
    check("abort_cout",     32'(cout),     32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_op("after_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
